// File: rtl/debouncer_event_if.sv
// Event-queue side of debouncer_event: head event handshake, occupancy,
// and the sticky overflow flag with its clear.
interface debouncer_event_if #(
  parameter int IW = 1,
  parameter int FA = 2
);
  logic          e_vld_o;
  logic          e_rdy_i;
  logic [1:0]    e_typ_o;
  logic [IW-1:0] e_idx_o;
  logic [FA:0]   cnt_o;
  logic          ovf_o;
  logic          clr_i;

  modport slave (
    output e_vld_o, e_typ_o, e_idx_o, cnt_o, ovf_o,
    input  e_rdy_i, clr_i
  );

  modport master (
    input  e_vld_o, e_typ_o, e_idx_o, cnt_o, ovf_o,
    output e_rdy_i, clr_i
  );
endinterface

// File: rtl/debouncer_event.sv
// Key event generator: turns debounced levels into press / release /
// long-press events, holds them in per-channel pending flags, and moves them
// one per cycle into a small first-word-fall-through FIFO for the consumer.
module debouncer_event #(
  parameter int DW = 2,
  parameter int IW = 1,
  parameter int LN = 50_000_000,
  parameter int CW = 26,
  parameter int FD = 4,
  parameter int FA = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d_i,
  debouncer_event_if.slave ev
);

  localparam logic [1:0]    TYP_REL   = 2'b00;
  localparam logic [1:0]    TYP_PRESS = 2'b01;
  localparam logic [1:0]    TYP_LONG  = 2'b10;
  localparam logic [CW-1:0] LN_M1     = CW'(LN - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [FA:0]   PTR_ONE   = {{FA{1'b0}}, 1'b1};
  localparam logic [FA:0]   FULL_CNT  = (FA+1)'(FD);

  // State flops and their next values
  logic [DW-1:0]   prev_q, prev_d;
  logic [DW-1:0]   long_done_q, long_done_d;
  logic [DW-1:0]   pp_q, pp_d;   // pending press
  logic [DW-1:0]   pl_q, pl_d;   // pending long
  logic [DW-1:0]   pr_q, pr_d;   // pending release
  logic [CW-1:0]   lcnt_q [DW];
  logic [CW-1:0]   lcnt_d [DW];
  logic [IW+1:0]   mem_q [FD];   // {typ, idx}
  logic [IW+1:0]   mem_d [FD];
  logic [FA:0]     wr_q, wr_d, rd_q, rd_d;
  logic            ovf_q, ovf_d;

  // Combinational helpers
  logic [DW-1:0]   rise_s, fall_s, long_s;
  logic [DW-1:0]   cand_p_s, cand_l_s, cand_r_s;
  logic [DW-1:0]   clr_p_s, clr_l_s, clr_r_s;
  logic            found_s, push_s, pop_s, full_s, empty_s, ovf_set_s;
  logic [1:0]      sel_typ_s;
  logic [IW-1:0]   sel_idx_s;
  logic [FA:0]     cnt_s;
  logic [IW+1:0]   head_s;

  // Edge detection and per-channel long-press timing
  always_comb begin
    prev_d      = d_i;
    rise_s      = d_i & ~prev_q;
    fall_s      = ~d_i & prev_q;
    long_s      = {DW{1'b0}};
    long_done_d = long_done_q;
    for (int i = 0; i < DW; i++) begin
      lcnt_d[i] = lcnt_q[i];
      if (fall_s[i]) begin
        lcnt_d[i]      = {CW{1'b0}};
        long_done_d[i] = 1'b0;
      end else if (d_i[i] && !long_done_q[i]) begin
        if (lcnt_q[i] == LN_M1) begin
          long_s[i]      = 1'b1;
          long_done_d[i] = 1'b1;
        end else begin
          lcnt_d[i] = lcnt_q[i] + CNT_ONE;
        end
      end else begin
        lcnt_d[i] = lcnt_q[i];
      end
    end
  end

  // Scheduler, pending flags, overflow flag and FIFO pointer/memory update
  always_comb begin
    cnt_s     = wr_q - rd_q;
    full_s    = (cnt_s == FULL_CNT);
    empty_s   = (cnt_s == {(FA+1){1'b0}});
    pop_s     = !empty_s && ev.e_rdy_i;
    found_s   = 1'b0;
    sel_idx_s = {IW{1'b0}};
    sel_typ_s = TYP_REL;
    cand_p_s  = {DW{1'b0}};
    cand_l_s  = {DW{1'b0}};
    cand_r_s  = {DW{1'b0}};
    // lowest index with anything pending wins; press > long > release
    for (int i = 0; i < DW; i++) begin
      if (!found_s && (pp_q[i] || pl_q[i] || pr_q[i])) begin
        found_s   = 1'b1;
        sel_idx_s = IW'(i);
        if (pp_q[i]) begin
          sel_typ_s   = TYP_PRESS;
          cand_p_s[i] = 1'b1;
        end else if (pl_q[i]) begin
          sel_typ_s   = TYP_LONG;
          cand_l_s[i] = 1'b1;
        end else begin
          sel_typ_s   = TYP_REL;
          cand_r_s[i] = 1'b1;
        end
      end else begin
        found_s = found_s;
      end
    end
    // a full FIFO still accepts a push when the head leaves this cycle
    push_s  = found_s && (!full_s || pop_s);
    clr_p_s = push_s ? cand_p_s : {DW{1'b0}};
    clr_l_s = push_s ? cand_l_s : {DW{1'b0}};
    clr_r_s = push_s ? cand_r_s : {DW{1'b0}};
    // a new set beats the clear of a bit being pushed right now
    pp_d = (pp_q & ~clr_p_s) | rise_s;
    pl_d = (pl_q & ~clr_l_s) | long_s;
    pr_d = (pr_q & ~clr_r_s) | fall_s;
    ovf_set_s = |(rise_s & pp_q & ~clr_p_s) |
                |(long_s & pl_q & ~clr_l_s) |
                |(fall_s & pr_q & ~clr_r_s);
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ev.clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_q[FA-1:0]] = {sel_typ_s, sel_idx_s};
      wr_d                = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
    if (empty_s) begin
      head_s = {(IW+2){1'b0}};
    end else begin
      head_s = mem_q[rd_q[FA-1:0]];
    end
  end

  // State register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= {DW{1'b0}};
      long_done_q <= {DW{1'b0}};
      pp_q        <= {DW{1'b0}};
      pl_q        <= {DW{1'b0}};
      pr_q        <= {DW{1'b0}};
      wr_q        <= {(FA+1){1'b0}};
      rd_q        <= {(FA+1){1'b0}};
      ovf_q       <= 1'b0;
      for (int i = 0; i < DW; i++) lcnt_q[i] <= {CW{1'b0}};
      for (int j = 0; j < FD; j++) mem_q[j] <= {(IW+2){1'b0}};
    end else begin
      prev_q      <= prev_d;
      long_done_q <= long_done_d;
      pp_q        <= pp_d;
      pl_q        <= pl_d;
      pr_q        <= pr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < DW; i++) lcnt_q[i] <= lcnt_d[i];
      for (int j = 0; j < FD; j++) mem_q[j] <= mem_d[j];
    end
  end

  assign ev.e_vld_o = !empty_s;
  assign ev.e_typ_o = head_s[IW+1:IW];
  assign ev.e_idx_o = head_s[IW-1:0];
  assign ev.cnt_o   = cnt_s;
  assign ev.ovf_o   = ovf_q;

endmodule
